baccarat_match_ctrl: RTL and testbench
======================================

// Module: baccarat_match_ctrl
// PURPOSE
//  Parametrised successor to the single-game baccarat datapath/FSM. It runs a full match of
//  NUM_GAMES rounds on one clock, and each round is advanced by a debounced step key.
//  It applies the full third-card tableau and keeps saturating player/dealer/tie tallies.
//  It sits between the card source (card_in, e.g. a dealcard LFSR) and the HEX/LEDR display logic.
// PARAMETERS
//  NUM_GAMES  8    rounds per match before MATCH_END
//  TALLY_W    4    width of each win tally; tallies saturate at 2**TALLY_W-1
//  AUTO_DIV   50   CLOCK_50 cycles per auto-step (used only with BACCARAT_AUTO_STEP_EN)
// PORTS
//  CLOCK_50     in   1        single clock
//  resetb       in   1        asynchronous, active-low reset
//  step_n       in   1        raw active-low step key (KEY[0]); asynchronous to CLOCK_50
//  card_in      in   4        card rank 1..13 from card source; sampled on the accepted step
//  pscore       out  4        player hand score 0..9
//  dscore       out  4        dealer hand score 0..9
//  p_count      out  2        cards in player hand 0..3
//  d_count      out  2        cards in dealer hand 0..3
//  player_win   out  1        round result; valid while game_done=1
//  dealer_win   out  1        round result; valid while game_done=1
//  tie          out  1        round result; valid while game_done=1
//  game_done    out  1        round resolved (RESULT state)
//  match_done   out  1        NUM_GAMES rounds played
//  p_tally      out  TALLY_W  player win count
//  d_tally      out  TALLY_W  dealer win count
//  t_tally      out  TALLY_W  tie count
//  games_played out  $clog2(NUM_GAMES+1)  completed rounds
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; state IDLE. Reset mid-round drops the hand.
//  - Step input: 2-flop synchroniser, then falling-edge detect gives a 1-cycle step pulse.
//    The pulse is seen 3 cycles after step_n falls. One pulse = one FSM advance.
//    All registered outputs update on the edge that consumes the pulse.
//  - Card points: rank 1..9 = face value; rank 10..13 and 0 = 0.
//  - Score: (score + points) mod 10, 4-bit. Wrap is via compare/subtract, not a divider.
//  - FSM sequence: IDLE -> P1 -> D1 -> P2 -> D2 -> EVAL -> [P3] -> [D3] -> RESULT -> IDLE | MATCH_END.
//    - IDLE, step: clear scores and counts.
//    - P1/D1/P2/D2, step: add card_in to that hand and increment its count.
//    - EVAL (no step needed, 1 cycle):
//      - pscore or dscore >= 8 (natural) -> RESULT.
//      - else pscore <= 5 -> P3.
//      - else (player stands) dscore <= 5 -> D3, otherwise RESULT.
//    - P3, step: add card (p3 = its points).
//      - Dealer draws when: ds<=2; ds=3 & p3!=8; ds=4 & p3 in 2..7; ds=5 & p3 in 4..7; ds=6 & p3 in 6..7.
//      - Draw -> D3; otherwise -> RESULT. ds=7 always stands.
//    - D3, step: add card -> RESULT.
//    - RESULT (entry cycle):
//      - Set exactly one of player_win/dealer_win/tie and game_done=1.
//      - Increment the matching tally (saturating) and games_played.
//    - RESULT, step: clear the result flags; go to MATCH_END if games_played==NUM_GAMES, else IDLE.
//    - MATCH_END: match_done=1; all steps ignored; tallies held until resetb.
//  - Simultaneous step pulse and reset: reset wins.
//  - card_in values 0 or 14..15 are accepted as 0 points.
// CONFIGURATION
//  BACCARAT_AUTO_STEP_EN defined:
//    - A free-running counter creates a step pulse every AUTO_DIV cycles; step_n is ignored.
//    - Counter resets to 0 with resetb.
//  BACCARAT_AUTO_STEP_EN undefined:
//    - Steps come only from step_n; no counter is synthesised.
// STRUCTURE
//  baccarat_pkg contents:
//    - state_t enum (IDLE,P1,D1,P2,D2,EVAL,P3,D3,RESULT,MATCH_END)
//    - RANK_W=4, SCORE_W=4
//    - function card_points(rank)
//    - function dealer_draws(ds,p3)
//  Sub-module key_step_sync: synchroniser + falling-edge detect.
//    - Ports CLOCK_50, resetb, key_n, step_pulse.
//  Top module contents: FSM, score datapath, result logic, tallies.
// TESTING
//  1 Natural: P 9,K; D 3,4 -> EVAL to RESULT; pscore=9, dscore=7, player_win=1, p_count=d_count=2, p_tally=1.
//  2 Player draws: P 2,3; D 10,7; P3=4 -> pscore=9; dealer 7 stands; player_win=1; p_count=3, d_count=2.
//  3 Tableau: P 1,2; D 2,4; P3=6 -> ds=6, p3=6, dealer draws 3 -> pscore=9, dscore=9; tie=1, t_tally=1.
//  4 NUM_GAMES=2: after round 2 RESULT step -> match_done=1, games_played=2; 5 further steps leave all outputs unchanged.
//  5 resetb low during D2 (async, mid-cycle) -> all outputs 0 immediately; next step starts a fresh round from IDLE.
//  6 TALLY_W=2: 4 player-win rounds -> p_tally=3 (saturated); step_n glitch <1 cycle wide -> no advance.

Source files
------------

// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared types, widths and card/tableau helpers for the baccarat match controller
package baccarat_pkg;

    localparam int RANK_W  = 4;
    localparam int SCORE_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        P1,
        D1,
        P2,
        D2,
        EVAL,
        P3,
        D3,
        RESULT,
        MATCH_END
    } state_t;

    // Ranks 1..9 score face value; tens, court cards and out-of-range codes score 0.
    function automatic logic [SCORE_W-1:0] card_points(input logic [RANK_W-1:0] rank);
        if (rank >= 4'd1 && rank <= 4'd9) begin
            return rank;
        end
        return '0;
    endfunction

    // Modulo-10 add of two 0..9 values by a single compare/subtract.
    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] a,
                                                     input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[SCORE_W-1:0];
    endfunction

    // Dealer third-card rule once the player has drawn a third card worth p3.
    function automatic logic dealer_draws(input logic [SCORE_W-1:0] ds,
                                          input logic [SCORE_W-1:0] p3);
        case (ds)
            4'd0, 4'd1, 4'd2: return 1'b1;
            4'd3:             return (p3 != 4'd8);
            4'd4:             return (p3 >= 4'd2 && p3 <= 4'd7);
            4'd5:             return (p3 >= 4'd4 && p3 <= 4'd7);
            4'd6:             return (p3 == 4'd6 || p3 == 4'd7);
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/key_step_sync.sv
// rtl/key_step_sync.sv - two-flop synchroniser and falling-edge detector for the step key
module key_step_sync (
    input  logic CLOCK_50,
    input  logic resetb,
    input  logic key_n,
    output logic step_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Flops reset to the released-key level so reset release never fakes a press.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign step_pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/baccarat_match_ctrl.sv
// rtl/baccarat_match_ctrl.sv - baccarat match FSM, score datapath and tallies; optional macro BACCARAT_AUTO_STEP_EN
module baccarat_match_ctrl
    import baccarat_pkg::*;
#(
    parameter int NUM_GAMES = 8,
    parameter int TALLY_W   = 4,
    parameter int AUTO_DIV  = 50
) (
    input  logic                           CLOCK_50,
    input  logic                           resetb,
    input  logic                           step_n,
    input  logic [RANK_W-1:0]              card_in,
    output logic [SCORE_W-1:0]             pscore,
    output logic [SCORE_W-1:0]             dscore,
    output logic [1:0]                     p_count,
    output logic [1:0]                     d_count,
    output logic                           player_win,
    output logic                           dealer_win,
    output logic                           tie,
    output logic                           game_done,
    output logic                           match_done,
    output logic [TALLY_W-1:0]             p_tally,
    output logic [TALLY_W-1:0]             d_tally,
    output logic [TALLY_W-1:0]             t_tally,
    output logic [$clog2(NUM_GAMES+1)-1:0] games_played
);

    localparam int GP_W = $clog2(NUM_GAMES + 1);
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    logic step;

`ifdef BACCARAT_AUTO_STEP_EN
    localparam int DIV_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    logic [DIV_W-1:0] div_q;
    logic             unused_step_n;

    assign unused_step_n = step_n;

    // Free-running divider standing in for the key: one step every AUTO_DIV cycles.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            div_q <= '0;
        end else if (div_q == DIV_W'(AUTO_DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign step = (div_q == DIV_W'(AUTO_DIV - 1));
`else
    key_step_sync u_key_step_sync (
        .CLOCK_50   (CLOCK_50),
        .resetb     (resetb),
        .key_n      (step_n),
        .step_pulse (step)
    );
`endif

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  pscore_q, pscore_d, dscore_q, dscore_d;
    logic [1:0]          p_count_q, p_count_d, d_count_q, d_count_d;
    logic                pwin_q, pwin_d, dwin_q, dwin_d, tie_q, tie_d;
    logic                done_q, done_d, match_q, match_d;
    logic [TALLY_W-1:0]  p_tally_q, p_tally_d, d_tally_q, d_tally_d, t_tally_q, t_tally_d;
    logic [GP_W-1:0]     games_q, games_d;
    logic [SCORE_W-1:0]  pts;

    assign pts = card_points(card_in);

    // State and all visible outputs are registered together.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            pscore_q  <= '0;
            dscore_q  <= '0;
            p_count_q <= '0;
            d_count_q <= '0;
            pwin_q    <= 1'b0;
            dwin_q    <= 1'b0;
            tie_q     <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            p_tally_q <= '0;
            d_tally_q <= '0;
            t_tally_q <= '0;
            games_q   <= '0;
        end else begin
            state_q   <= state_d;
            pscore_q  <= pscore_d;
            dscore_q  <= dscore_d;
            p_count_q <= p_count_d;
            d_count_q <= d_count_d;
            pwin_q    <= pwin_d;
            dwin_q    <= dwin_d;
            tie_q     <= tie_d;
            done_q    <= done_d;
            match_q   <= match_d;
            p_tally_q <= p_tally_d;
            d_tally_q <= d_tally_d;
            t_tally_q <= t_tally_d;
            games_q   <= games_d;
        end
    end

    // Next state, hand arithmetic, and the one-shot result/tally update on entry to RESULT.
    always_comb begin
        state_d   = state_q;
        pscore_d  = pscore_q;
        dscore_d  = dscore_q;
        p_count_d = p_count_q;
        d_count_d = d_count_q;
        pwin_d    = pwin_q;
        dwin_d    = dwin_q;
        tie_d     = tie_q;
        done_d    = done_q;
        match_d   = match_q;
        p_tally_d = p_tally_q;
        d_tally_d = d_tally_q;
        t_tally_d = t_tally_q;
        games_d   = games_q;

        case (state_q)
            IDLE: if (step) begin
                pscore_d  = '0;
                dscore_d  = '0;
                p_count_d = '0;
                d_count_d = '0;
                state_d   = P1;
            end
            P1, P2: if (step) begin
                pscore_d  = score_add(pscore_q, pts);
                p_count_d = p_count_q + 2'd1;
                state_d   = (state_q == P1) ? D1 : D2;
            end
            D1, D2: if (step) begin
                dscore_d  = score_add(dscore_q, pts);
                d_count_d = d_count_q + 2'd1;
                state_d   = (state_q == D1) ? P2 : EVAL;
            end
            EVAL: begin
                if (pscore_q >= 4'd8 || dscore_q >= 4'd8) begin
                    state_d = RESULT;
                end else if (pscore_q <= 4'd5) begin
                    state_d = P3;
                end else if (dscore_q <= 4'd5) begin
                    state_d = D3;
                end else begin
                    state_d = RESULT;
                end
            end
            P3: if (step) begin
                pscore_d  = score_add(pscore_q, pts);
                p_count_d = p_count_q + 2'd1;
                state_d   = dealer_draws(dscore_q, pts) ? D3 : RESULT;
            end
            D3: if (step) begin
                dscore_d  = score_add(dscore_q, pts);
                d_count_d = d_count_q + 2'd1;
                state_d   = RESULT;
            end
            RESULT: if (step) begin
                pwin_d = 1'b0;
                dwin_d = 1'b0;
                tie_d  = 1'b0;
                done_d = 1'b0;
                if (games_q == GP_W'(NUM_GAMES)) begin
                    state_d = MATCH_END;
                    match_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MATCH_END: state_d = MATCH_END;
            default:   state_d = IDLE;
        endcase

        if (state_d == RESULT && state_q != RESULT) begin
            done_d  = 1'b1;
            games_d = games_q + 1'b1;
            if (pscore_d > dscore_d) begin
                pwin_d = 1'b1;
                if (p_tally_q != TALLY_MAX) p_tally_d = p_tally_q + 1'b1;
            end else if (dscore_d > pscore_d) begin
                dwin_d = 1'b1;
                if (d_tally_q != TALLY_MAX) d_tally_d = d_tally_q + 1'b1;
            end else begin
                tie_d = 1'b1;
                if (t_tally_q != TALLY_MAX) t_tally_d = t_tally_q + 1'b1;
            end
        end
    end

    assign pscore       = pscore_q;
    assign dscore       = dscore_q;
    assign p_count      = p_count_q;
    assign d_count      = d_count_q;
    assign player_win   = pwin_q;
    assign dealer_win   = dwin_q;
    assign tie          = tie_q;
    assign game_done    = done_q;
    assign match_done   = match_q;
    assign p_tally      = p_tally_q;
    assign d_tally      = d_tally_q;
    assign t_tally      = t_tally_q;
    assign games_played = games_q;

endmodule

// File: tb/tb_baccarat_match_ctrl.sv
// tb/tb_baccarat_match_ctrl.sv - scoreboard bench for baccarat_match_ctrl
module tb_baccarat_match_ctrl;

    localparam int NG   = 6;
    localparam int TW   = 2;
    localparam int GP_W = $clog2(NG + 1);
    localparam int TMAX = (1 << TW) - 1;

    logic            CLOCK_50 = 1'b0;
    logic            resetb   = 1'b0;
    logic            step_n   = 1'b1;
    logic [3:0]      card_in  = 4'd0;
    logic [3:0]      pscore, dscore;
    logic [1:0]      p_count, d_count;
    logic            player_win, dealer_win, tie, game_done, match_done;
    logic [TW-1:0]   p_tally, d_tally, t_tally;
    logic [GP_W-1:0] games_played;

    baccarat_match_ctrl #(.NUM_GAMES(NG), .TALLY_W(TW), .AUTO_DIV(50)) dut (
        .CLOCK_50     (CLOCK_50),
        .resetb       (resetb),
        .step_n       (step_n),
        .card_in      (card_in),
        .pscore       (pscore),
        .dscore       (dscore),
        .p_count      (p_count),
        .d_count      (d_count),
        .player_win   (player_win),
        .dealer_win   (dealer_win),
        .tie          (tie),
        .game_done    (game_done),
        .match_done   (match_done),
        .p_tally      (p_tally),
        .d_tally      (d_tally),
        .t_tally      (t_tally),
        .games_played (games_played)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int ps; int ds; int pc; int dc;
        int pw; int dw; int tw;
        int pt; int dt; int tt; int gp;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_pt = 0, m_dt = 0, m_tt = 0, m_gp = 0;

    function automatic int pts(input int r);
        return (r >= 1 && r <= 9) ? r : 0;
    endfunction

    function automatic int draw_rule(input int ds, input int p3);
        if (ds <= 2) return 1;
        if (ds == 3) return (p3 == 8) ? 0 : 1;
        if (ds == 4) return (p3 >= 2 && p3 <= 7) ? 1 : 0;
        if (ds == 5) return (p3 >= 4 && p3 <= 7) ? 1 : 0;
        if (ds == 6) return (p3 == 6 || p3 == 7) ? 1 : 0;
        return 0;
    endfunction

    task automatic press(input int card);
        card_in = 4'(card);
        step_n  = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        step_n  = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic play_round(input int p1, input int d1, input int p2, input int d2,
                              input int p3, input int d3);
        exp_t e;
        exp_t got;
        int   n;
        press(0);
        press(p1);
        press(d1);
        press(p2);
        press(d2);
        e.ps = (pts(p1) + pts(p2)) % 10;
        e.ds = (pts(d1) + pts(d2)) % 10;
        e.pc = 2;
        e.dc = 2;
        if (!(e.ps >= 8 || e.ds >= 8)) begin
            if (e.ps <= 5) begin
                press(p3);
                e.ps = (e.ps + pts(p3)) % 10;
                e.pc = 3;
                if (draw_rule(e.ds, pts(p3)) != 0) begin
                    press(d3);
                    e.ds = (e.ds + pts(d3)) % 10;
                    e.dc = 3;
                end
            end else if (e.ds <= 5) begin
                press(d3);
                e.ds = (e.ds + pts(d3)) % 10;
                e.dc = 3;
            end
        end
        e.pw = (e.ps > e.ds) ? 1 : 0;
        e.dw = (e.ds > e.ps) ? 1 : 0;
        e.tw = (e.ps == e.ds) ? 1 : 0;
        if (e.pw == 1 && m_pt < TMAX) m_pt++;
        if (e.dw == 1 && m_dt < TMAX) m_dt++;
        if (e.tw == 1 && m_tt < TMAX) m_tt++;
        m_gp++;
        e.pt = m_pt; e.dt = m_dt; e.tt = m_tt; e.gp = m_gp;
        sb.push_back(e);

        n = 0;
        while (game_done !== 1'b1 && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        vectors++;
        if (game_done !== 1'b1) begin
            miscompares++;
            $display("FAIL round_done_timeout: game_done=%b required 1", game_done);
            void'(sb.pop_front());
        end else begin
            got = sb.pop_front();
            vectors++;
            if ({pscore, dscore, p_count, d_count} !== {4'(got.ps), 4'(got.ds), 2'(got.pc), 2'(got.dc)}) begin
                miscompares++;
                $display("FAIL round_hands: ps=%0d ds=%0d pc=%0d dc=%0d required ps=%0d ds=%0d pc=%0d dc=%0d",
                         pscore, dscore, p_count, d_count, got.ps, got.ds, got.pc, got.dc);
            end
            vectors++;
            if ({player_win, dealer_win, tie} !== {1'(got.pw), 1'(got.dw), 1'(got.tw)}) begin
                miscompares++;
                $display("FAIL round_flags: pwdwt=%b%b%b required %0d%0d%0d",
                         player_win, dealer_win, tie, got.pw, got.dw, got.tw);
            end
            vectors++;
            if ({p_tally, d_tally, t_tally, games_played} !== {TW'(got.pt), TW'(got.dt), TW'(got.tt), GP_W'(got.gp)}) begin
                miscompares++;
                $display("FAIL round_tallies: p=%0d d=%0d t=%0d g=%0d required p=%0d d=%0d t=%0d g=%0d",
                         p_tally, d_tally, t_tally, games_played, got.pt, got.dt, got.tt, got.gp);
            end
            last = got;
        end

        press(0);
        vectors++;
        if ({game_done, player_win, dealer_win, tie, match_done} !== {4'b0000, (m_gp == NG)}) begin
            miscompares++;
            $display("FAIL result_clear: done=%b flags=%b%b%b match=%b required done=0 flags=000 match=%0d",
                     game_done, player_win, dealer_win, tie, match_done, (m_gp == NG));
        end
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        vectors++;
        if ({pscore, dscore, p_count, d_count, player_win, dealer_win, tie, game_done, match_done,
             p_tally, d_tally, t_tally, games_played} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ps=%0d ds=%0d pc=%0d dc=%0d done=%b match=%b g=%0d required all 0",
                     pscore, dscore, p_count, d_count, game_done, match_done, games_played);
        end
        resetb = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_natural;
        play_round(9, 3, 13, 4, 0, 0);
    endtask

    task automatic test_player_draws;
        play_round(2, 10, 3, 7, 4, 0);
    endtask

    task automatic test_tableau;
        play_round(1, 2, 2, 4, 6, 3);
    endtask

    task automatic test_glitch;
        @(negedge CLOCK_50);
        #1 step_n = 1'b0;
        #2 step_n = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        vectors++;
        if ({pscore, dscore, p_count, d_count} !== {4'(last.ps), 4'(last.ds), 2'(last.pc), 2'(last.dc)}) begin
            miscompares++;
            $display("FAIL glitch_ignored: ps=%0d ds=%0d pc=%0d dc=%0d required ps=%0d ds=%0d pc=%0d dc=%0d",
                     pscore, dscore, p_count, d_count, last.ps, last.ds, last.pc, last.dc);
        end
    endtask

    task automatic test_reset_mid_round;
        press(0);
        press(5);
        press(6);
        press(2);
        @(negedge CLOCK_50);
        #2 resetb = 1'b0;
        #1;
        vectors++;
        if ({pscore, dscore, p_count, d_count, player_win, dealer_win, tie, game_done, match_done,
             p_tally, d_tally, t_tally, games_played} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: ps=%0d ds=%0d pc=%0d dc=%0d pt=%0d tt=%0d g=%0d required all 0",
                     pscore, dscore, p_count, d_count, p_tally, t_tally, games_played);
        end
        @(negedge CLOCK_50);
        resetb = 1'b1;
        m_pt = 0; m_dt = 0; m_tt = 0; m_gp = 0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_saturation;
        play_round(8, 2, 10, 3, 0, 0);
        play_round(9, 0, 14, 0, 0, 0);
        play_round(4, 5, 4, 2, 0, 0);
        play_round(7, 1, 12, 0, 0, 5);
    endtask

    task automatic test_back_to_back;
        play_round(1, 9, 1, 0, 0, 0);
        play_round(5, 5, 3, 3, 0, 0);
    endtask

    task automatic test_match_end;
        for (int i = 0; i < 5; i++) press(i + 3);
        vectors++;
        if ({pscore, dscore, p_count, d_count, player_win, dealer_win, tie, game_done, match_done,
             p_tally, d_tally, t_tally, games_played} !==
            {4'(last.ps), 4'(last.ds), 2'(last.pc), 2'(last.dc), 4'b0000, 1'b1,
             TW'(m_pt), TW'(m_dt), TW'(m_tt), GP_W'(NG)}) begin
            miscompares++;
            $display("FAIL match_end_hold: ps=%0d ds=%0d match=%b pt=%0d dt=%0d tt=%0d g=%0d required ps=%0d ds=%0d match=1 pt=%0d dt=%0d tt=%0d g=%0d",
                     pscore, dscore, match_done, p_tally, d_tally, t_tally, games_played,
                     last.ps, last.ds, m_pt, m_dt, m_tt, NG);
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_player_draws();
        test_tableau();
        test_glitch();
        test_reset_mid_round();
        test_saturation();
        test_back_to_back();
        test_match_end();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
